ifm_bram_reader: RTL

- Read-side initiator for the IFM block RAM (32-bit words, byte-addressed read port, word index = rd_addr >> 2, one registered read cycle).
- On a start command, sweeps a contiguous range of words and drives rd_addr with byte addresses stepping by 4.
- Absorbs the BRAM read latency and returns the words in order on a valid/ready stream to the downstream PE/line-buffer logic.
- Credit-based issue plus a small FIFO give full throughput under continuous ready, with no loss under backpressure.

---
 rtl/ifm_bram_reader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ifm_bram_reader.sv
// IFM block-RAM read initiator.
// Sweeps a contiguous word range, absorbs the one-cycle registered BRAM
// latency, and streams the words in order on a valid/ready interface.
// Reads are only issued when the FIFO has space for them, so the FIFO
// can never overflow when the consumer stalls.
module ifm_bram_reader #(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  issued_q;
  logic [CNT_W-1:0]  pushed_q;
  logic              v1_q;
  logic              v2_q;
  logic              busy_q;
  logic              done_q;

  logic [DATA_W-1:0] mem_q      [FIFO_DEPTH];
  logic              last_mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wp_q;
  logic [PW-1:0]     rp_q;
  logic [CW-1:0]     cnt_q;

  logic              issue;
  logic              push;
  logic              pop;
  logic              push_last;
  logic              pop_last;
  logic [CW-1:0]     cnt_d;
  logic [PW-1:0]     wp_d;
  logic [PW-1:0]     rp_d;

  // Issue credit, FIFO push/pop decisions and pointer/count next-state.
  // Credit counts FIFO occupancy plus reads still in the two-stage pipe.
  always_comb begin
    issue     = (state_q == RUN) && (issued_q < num_q) &&
                ((32'(cnt_q) + 32'(v1_q) + 32'(v2_q)) < 32'(FIFO_DEPTH));
    push      = v2_q;
    pop       = (cnt_q != '0) && m_ready;
    push_last = (pushed_q == (num_q - CNT_W'(1)));
    pop_last  = pop && last_mem_q[rp_q];
    wp_d      = (wp_q == PW'(FIFO_DEPTH - 1)) ? '0 : wp_q + PW'(1);
    rp_d      = (rp_q == PW'(FIFO_DEPTH - 1)) ? '0 : rp_q + PW'(1);
    cnt_d     = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);
  end

  // Sweep FSM, read pipeline tracking and output FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      base_q    <= '0;
      rd_addr_q <= '0;
      num_q     <= '0;
      issued_q  <= '0;
      pushed_q  <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i]      <= '0;
        last_mem_q[i] <= 1'b0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (num_words != '0) begin
              base_q   <= base_addr;
              num_q    <= num_words;
              issued_q <= '0;
              pushed_q <= '0;
              busy_q   <= 1'b1;
              state_q  <= RUN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            rd_addr_q <= base_q + (ADDR_W'(issued_q) << 2);
            issued_q  <= issued_q + CNT_W'(1);
            if ((issued_q + CNT_W'(1)) == num_q) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop_last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      v1_q <= issue;
      v2_q <= v1_q;

      if (push) begin
        mem_q[wp_q]      <= bram_dout;
        last_mem_q[wp_q] <= push_last;
        wp_q             <= wp_d;
        pushed_q         <= pushed_q + CNT_W'(1);
      end
      if (pop) rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign rd_addr = rd_addr_q;
  assign m_data  = mem_q[rp_q];
  assign m_valid = (cnt_q != '0);
  assign m_last  = (cnt_q != '0) && last_mem_q[rp_q];
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
